// File: rtl/bit_count_pkg.sv
// Shared types and defaults for the sequential population counter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bit_count_pkg;

  // Default operand width and bits examined per BUSY cycle.
  localparam int BC_WIDTH = 32;
  localparam int BC_STEP  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } bc_state_t;

endpackage

// File: rtl/bit_count_if.sv
// Level-handshake bundle between a controller (master) and bit_count (slave).
// Latency: n/a (wires only).
// Backpressure: master holds start high until finish is seen, then drops it.
//   start    : level request from master
//   in       : operand, sampled by the slave when it leaves IDLE
//   finish   : result valid while start is still high
//   bitcount : zero-extended population count of the latched operand
interface bit_count_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic [WIDTH-1:0] in;
  logic             finish;
  logic [WIDTH-1:0] bitcount;

  modport master (
    output start,
    output in,
    input  finish,
    input  bitcount
  );

  modport slave (
    input  start,
    input  in,
    output finish,
    output bitcount
  );

endinterface

// File: rtl/bit_count_popcount_chunk.sv
// Combinational popcount of one STEP-bit slice of the operand.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//   bits_i  : STEP bits to count
//   count_o : number of set bits, $clog2(STEP+1) bits wide
module popcount_chunk #(
  parameter int STEP = 1
) (
  input  logic [STEP-1:0]              bits_i,
  output logic [$clog2(STEP+1)-1:0]    count_o
);

  localparam int CW = $clog2(STEP + 1);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < STEP; i++) begin
      count_o = count_o + CW'(bits_i[i]);
    end
  end

endmodule

// File: rtl/bit_count.sv
// Sequential population counter: latches a word on start, counts STEP bits per cycle.
// Latency: finish rises WIDTH/STEP+1 clock edges after start is first sampled high.
// Backpressure: level handshake; result held in DONE until start drops, start low in BUSY aborts.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : slave side of bit_count_if (start/in in, finish/bitcount out)
module bit_count
  import bit_count_pkg::*;
#(
  parameter int WIDTH = BC_WIDTH,
  parameter int STEP  = BC_STEP
) (
  input  logic        clk,
  input  logic        rst,
  bit_count_if.slave  bus
);

  localparam int NCHUNK = WIDTH / STEP;
  localparam int AW     = $clog2(WIDTH + 1);
  localparam int CNT_W  = $clog2(NCHUNK + 1);
  localparam int PW     = $clog2(STEP + 1);

  generate
    if (WIDTH % STEP != 0) begin : g_bad_step
      $error("bit_count: STEP must divide WIDTH");
    end
  endgenerate

  bc_state_t        state_q,    state_d;
  logic [WIDTH-1:0] shreg_q,    shreg_d;
  logic [AW-1:0]    acc_q,      acc_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic             finish_q,   finish_d;
  logic [WIDTH-1:0] bitcount_q, bitcount_d;

  logic [PW-1:0]    chunk_cnt;
  logic [AW-1:0]    acc_sum;

  popcount_chunk #(.STEP(STEP)) u_chunk (
    .bits_i  (shreg_q[STEP-1:0]),
    .count_o (chunk_cnt)
  );

  // Running total including the slice currently at the bottom of shreg.
  assign acc_sum = acc_q + AW'(chunk_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      finish_q   <= 1'b0;
      bitcount_q <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      finish_q   <= finish_d;
      bitcount_q <= bitcount_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    finish_d   = finish_q;
    bitcount_d = bitcount_q;

    case (state_q)
      IDLE: begin
        finish_d = 1'b0;
        if (bus.start) begin
          state_d = BUSY;
          shreg_d = bus.in;
          acc_d   = '0;
          cnt_d   = CNT_W'(NCHUNK);
        end
      end

      BUSY: begin
        if (!bus.start) begin
          // Abort: drop the partial sum, previous bitcount stays visible.
          state_d = IDLE;
        end else begin
          acc_d   = acc_sum;
          shreg_d = shreg_q >> STEP;
          cnt_d   = cnt_q - CNT_W'(1);
          // Last slice: publish the sum that includes it on the same edge.
          if (cnt_q == CNT_W'(1)) begin
            state_d    = DONE;
            bitcount_d = WIDTH'(acc_sum);
            finish_d   = 1'b1;
          end
        end
      end

      DONE: begin
        // Stay here while start is held so a stuck start cannot re-trigger.
        if (!bus.start) begin
          state_d  = IDLE;
          finish_d = 1'b0;
        end
      end

      default: begin
        state_d  = IDLE;
        finish_d = 1'b0;
      end
    endcase
  end

  assign bus.finish   = finish_q;
  assign bus.bitcount = bitcount_q;

endmodule

// File: tb/tb_bit_count.sv
// Self-checking bench for bit_count: directed operands with a scoreboard queue.
// Latency: checks finish arrives exactly 33 edges after start at WIDTH=32, STEP=1.
// Backpressure: drives the level handshake as a master, including abort and reset.
module tb_bit_count;

  logic clk;
  logic rst;

  int n_checks;
  int n_errors;

  logic [31:0] exp_q[$];

  bit_count_if #(.WIDTH(32)) bus ();

  bit_count #(.WIDTH(32), .STEP(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Wait for finish after start has been raised, then check and release.
  task automatic finish_op(input logic [31:0] expected, input int hold);
    int          cycles;
    logic [31:0] exp;
    logic [31:0] held_in;
    exp_q.push_back(expected);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (!bus.finish && cycles < 100);
    check_val("latency", cycles, 33);
    exp = exp_q.pop_front();
    check_val("bitcount", bus.bitcount, exp);
    if (hold > 0) begin
      // Operand changes while DONE must not disturb the result.
      held_in = bus.in;
      bus.in  = ~held_in;
      repeat (hold) @(posedge clk);
      #1;
      check_val("hold_finish", 32'(bus.finish), 32'd1);
      check_val("hold_bitcount", bus.bitcount, exp);
    end
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    check_val("finish_drop", 32'(bus.finish), 32'd0);
    check_val("bitcount_kept", bus.bitcount, exp);
  endtask

  task automatic run_op(input logic [31:0] operand, input logic [31:0] expected, input int hold);
    @(negedge clk);
    bus.in    = operand;
    bus.start = 1'b1;
    finish_op(expected, hold);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.in    = '0;

    repeat (2) @(posedge clk);
    #1;
    check_val("reset_finish", 32'(bus.finish), 32'd0);
    check_val("reset_bitcount", bus.bitcount, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(32'h0000_0000, 32'd0, 0);
    run_op(32'h8000_0000, 32'd1, 0);
    run_op(32'h8000_0800, 32'd2, 0);
    run_op(32'h8408_0804, 32'd5, 0);
    run_op(32'h9010_C83C, 32'd10, 3);
    run_op(32'hF852_4A22, 32'd13, 0);
    run_op(32'hFF00_FF00, 32'd16, 0);
    run_op(32'h00FF_00FF, 32'd16, 0);
    run_op(32'hFFFF_FFFF, 32'd32, 5);
    run_op(32'h0000_0000, 32'd0, 0);
    run_op(32'hFFFF_FFFF, 32'd32, 0);

    // Abort after ten busy edges.
    @(negedge clk);
    bus.in    = 32'h1234_5678;
    bus.start = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.finish) seen = 1;
    end
    check_val("abort_finish", 32'(seen), 32'd0);
    check_val("abort_bitcount", bus.bitcount, 32'd32);
    run_op(32'h0000_000F, 32'd4, 0);

    // Reset in the middle of BUSY clears outputs immediately.
    @(negedge clk);
    bus.in    = 32'hFFFF_0000;
    bus.start = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("rst_mid_finish", 32'(bus.finish), 32'd0);
    check_val("rst_mid_bitcount", bus.bitcount, 32'd0);
    bus.start = 1'b0;
    @(posedge clk);
    // Release reset with start already high.
    @(negedge clk);
    rst       = 1'b0;
    bus.in    = 32'h0000_F0F0;
    bus.start = 1'b1;
    finish_op(32'd8, 0);

    check_val("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
